// File: rtl/drum_strike_detector.sv
// Drum strike detector: watches the gyro strike axis for a downward swing,
// tracks its peak, and on release emits a one-cycle hit with the drum zone
// (from yaw/pitch captured at strike onset) and a 7-bit velocity.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a qualified sample below the strike threshold
// STRIKE   | swing in progress, tracking the most negative gyro_y
// COOLDOWN | lockout after a hit, all samples ignored
module drum_strike_detector #(
  parameter logic signed [15:0] STRIKE_THRESH   = -16'sd2000,
  parameter logic signed [15:0] RELEASE_THRESH  = -16'sd500,
  parameter logic signed [15:0] YAW_LEFT        = -16'sd1000,
  parameter logic signed [15:0] YAW_RIGHT       = 16'sd1000,
  parameter logic signed [15:0] PITCH_HIGH      = 16'sd1500,
  parameter logic        [23:0] COOLDOWN_CYCLES = 24'd500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_strobe,
  input  logic               initialized,
  input  logic               error,
  input  logic               quat1_valid,
  input  logic signed [15:0] quat1_x,
  input  logic signed [15:0] quat1_y,
  input  logic signed [15:0] quat1_z,
  input  logic               gyro1_valid,
  input  logic signed [15:0] gyro1_x,
  input  logic signed [15:0] gyro1_y,
  input  logic signed [15:0] gyro1_z,
  output logic               hit_pulse,
  output logic [1:0]         hit_drum,
  output logic [6:0]         hit_velocity,
  output logic [7:0]         hit_count,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] STRIKE   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic signed [15:0] peak;
  logic [1:0]         zone;
  logic [23:0]        cd_cnt;

  logic               qualified;
  logic               arm;
  logic               abort;
  logic               fire;
  logic [1:0]         zone_sel;
  logic [16:0]        mag;
  logic [16:0]        mag_shr;
  logic [6:0]         vel_calc;

  // Roll and the off-axis gyro channels are not used for detection.
  logic unused_inputs;
  assign unused_inputs = ^{quat1_x, gyro1_x, gyro1_z};

  // Sample qualification, strike arming, abort and release decode
  always_comb begin
    qualified = sample_strobe & initialized & ~error & quat1_valid & gyro1_valid;
    arm       = qualified && (gyro1_y < STRIKE_THRESH);
    abort     = error | ~initialized;
    fire      = (state == STRIKE) && !abort && qualified && (gyro1_y >= RELEASE_THRESH);
  end

  // Drum zone from current attitude; pitch overrides yaw
  always_comb begin
    zone_sel = 2'd2;
    if (quat1_y > PITCH_HIGH)      zone_sel = 2'd3;
    else if (quat1_z < YAW_LEFT)   zone_sel = 2'd0;
    else if (quat1_z < YAW_RIGHT)  zone_sel = 2'd1;
  end

  // Velocity: 17-bit negate so -32768 maps to +32768, then >>8 and clamp
  always_comb begin
    mag      = 17'd0 - {peak[15], peak};
    mag_shr  = mag >> 8;
    vel_calc = (mag_shr > 17'd127) ? 7'd127 : mag_shr[6:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (arm) state_nxt = STRIKE;
      STRIKE: begin
        if (abort)     state_nxt = IDLE;
        else if (fire) state_nxt = COOLDOWN;
      end
      COOLDOWN: if (cd_cnt == 24'd0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    state_dbg = state;
  end

  // Peak tracking and zone capture at strike onset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
      zone <= '0;
    end else if (state == IDLE && arm) begin
      peak <= gyro1_y;
      zone <= zone_sel;
    end else if (state == STRIKE && !abort && qualified && gyro1_y < peak) begin
      peak <= gyro1_y;
    end
  end

  // Cooldown down-counter, loaded on the hit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  cd_cnt <= '0;
    else if (fire)                               cd_cnt <= COOLDOWN_CYCLES - 24'd1;
    else if (state == COOLDOWN && cd_cnt != '0)  cd_cnt <= cd_cnt - 24'd1;
  end

  // Hit outputs, updated on the release edge and held until the next hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_pulse    <= 1'b0;
      hit_drum     <= '0;
      hit_velocity <= '0;
      hit_count    <= '0;
    end else begin
      hit_pulse <= fire;
      if (fire) begin
        hit_drum     <= zone;
        hit_velocity <= vel_calc;
        hit_count    <= hit_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_drum_strike_detector.sv
// Directed bench for drum_strike_detector with a short cooldown.
module tb_drum_strike_detector;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sample_strobe;
  logic               initialized;
  logic               error;
  logic               quat1_valid;
  logic signed [15:0] quat1_x, quat1_y, quat1_z;
  logic               gyro1_valid;
  logic signed [15:0] gyro1_x, gyro1_y, gyro1_z;
  logic               hit_pulse;
  logic [1:0]         hit_drum;
  logic [6:0]         hit_velocity;
  logic [7:0]         hit_count;
  logic [1:0]         state_dbg;

  int checks = 0;
  int failures = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] exp_cnt;

  drum_strike_detector #(.COOLDOWN_CYCLES(24'd100)) dut (
    .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe),
    .initialized(initialized), .error(error), .quat1_valid(quat1_valid),
    .quat1_x(quat1_x), .quat1_y(quat1_y), .quat1_z(quat1_z),
    .gyro1_valid(gyro1_valid), .gyro1_x(gyro1_x), .gyro1_y(gyro1_y),
    .gyro1_z(gyro1_z), .hit_pulse(hit_pulse), .hit_drum(hit_drum),
    .hit_velocity(hit_velocity), .hit_count(hit_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] gy;
    logic signed [15:0] yaw;
    logic signed [15:0] pitch;
    logic               gv;
    logic [1:0]         st;
    logic               pulse;
    logic [1:0]         drum;
    logic [6:0]         vel;
    logic [7:0]         cnt;
    int                 wait_c;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int gy, input int yaw, input int pitch, input int gv,
                              input int st, input int pulse, input int drum, input int vel,
                              input int cnt, input int wait_c);
    vec_t v;
    v.gy = 16'(gy); v.yaw = 16'(yaw); v.pitch = 16'(pitch); v.gv = gv[0];
    v.st = st[1:0]; v.pulse = pulse[0]; v.drum = drum[1:0]; v.vel = vel[6:0];
    v.cnt = cnt[7:0]; v.wait_c = wait_c;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] gy, input logic signed [15:0] yaw,
                      input logic signed [15:0] pitch, input logic gv);
    @(posedge clk); #1;
    gyro1_y = gy; quat1_z = yaw; quat1_y = pitch; gyro1_valid = gv;
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_state"}, int'(state_dbg), 0);
    chk({tag, "_pulse"}, int'(hit_pulse), 0);
    chk({tag, "_drum"}, int'(hit_drum), 0);
    chk({tag, "_vel"}, int'(hit_velocity), 0);
    chk({tag, "_count"}, int'(hit_count), 0);
  endtask

  // Hit pulses must never be back-to-back
  always @(negedge clk) begin
    if (hit_pulse) begin
      checks++;
      if (prev_pulse) begin
        failures++;
        $display("FAIL pulse_consecutive: got 1 expected 0");
      end
    end
    prev_pulse <= hit_pulse;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sample_strobe = 1'b0; initialized = 1'b1; error = 1'b0;
    quat1_valid = 1'b1; gyro1_valid = 1'b1;
    quat1_x = '0; quat1_y = '0; quat1_z = '0; gyro1_x = '0; gyro1_y = '0; gyro1_z = '0;

    //            gy    yaw    pitch gv st p drum vel cnt wait
    tbl.push_back(mk(-3000,     0,    0, 1, 1, 0, 0,   0, 0,   0));
    tbl.push_back(mk(-6000,     0,    0, 1, 1, 0, 0,   0, 0,   0));
    tbl.push_back(mk(-4000,     0,    0, 1, 1, 0, 0,   0, 0,   0));
    tbl.push_back(mk( -200,     0,    0, 1, 2, 1, 1,  23, 1, 100));
    tbl.push_back(mk(-3000, -2000,    0, 1, 1, 0, 1,  23, 1,   0));
    tbl.push_back(mk(    0, -2000,    0, 1, 2, 1, 0,  11, 2, 100));
    tbl.push_back(mk(-2001,  2000,    0, 1, 1, 0, 0,  11, 2,   0));
    tbl.push_back(mk( -500,  2000,    0, 1, 2, 1, 2,   7, 3, 100));
    tbl.push_back(mk(-2000, -2000, 2000, 1, 0, 0, 2,   7, 3,   0));
    tbl.push_back(mk(-2560, -2000, 2000, 1, 1, 0, 2,   7, 3,   0));
    tbl.push_back(mk( -501, -2000, 2000, 1, 1, 0, 2,   7, 3,   0));
    tbl.push_back(mk(  100, -2000, 2000, 1, 2, 1, 3,  10, 4, 100));
    tbl.push_back(mk(-32768,    0,    0, 1, 1, 0, 3,  10, 4,   0));
    tbl.push_back(mk(-1000,     0,    0, 1, 1, 0, 3,  10, 4,   0));
    tbl.push_back(mk(    0,     0,    0, 1, 2, 1, 1, 127, 5, 100));
    tbl.push_back(mk(-5000,     0,    0, 0, 0, 0, 1, 127, 5,   0));
    tbl.push_back(mk(-5000,     0,    0, 0, 0, 0, 1, 127, 5,   0));
    tbl.push_back(mk(-5000, -1000, 1500, 1, 1, 0, 1, 127, 5,   0));
    tbl.push_back(mk(-7000, -1000, 1500, 1, 1, 0, 1, 127, 5,   0));
    tbl.push_back(mk(-1000, -1000, 1500, 1, 1, 0, 1, 127, 5,   0));
    tbl.push_back(mk( -500, -1000, 1500, 1, 2, 1, 1,  27, 6, 100));
    tbl.push_back(mk(-3000,  1000, 1501, 1, 1, 0, 1,  27, 6,   0));
    tbl.push_back(mk(    0,  1000, 1501, 1, 2, 1, 3,  11, 7, 100));
    tbl.push_back(mk(-3000,  1000,    0, 1, 1, 0, 3,  11, 7,   0));
    tbl.push_back(mk(    0,  1000,    0, 1, 2, 1, 2,  11, 8, 100));

    tick(3);
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      send(tbl[i].gy, tbl[i].yaw, tbl[i].pitch, tbl[i].gv);
      chk($sformatf("v%0d_state", i), int'(state_dbg), int'(tbl[i].st));
      chk($sformatf("v%0d_pulse", i), int'(hit_pulse), int'(tbl[i].pulse));
      chk($sformatf("v%0d_drum", i), int'(hit_drum), int'(tbl[i].drum));
      chk($sformatf("v%0d_vel", i), int'(hit_velocity), int'(tbl[i].vel));
      chk($sformatf("v%0d_count", i), int'(hit_count), int'(tbl[i].cnt));
      if (tbl[i].wait_c > 0) begin
        tick(1);
        chk($sformatf("v%0d_pulse_off", i), int'(hit_pulse), 0);
        tick(tbl[i].wait_c - 1);
        chk($sformatf("v%0d_after_cd", i), int'(state_dbg), 0);
      end
    end
    exp_cnt = 8'd8;

    // Cooldown: pattern 50 clk after the hit is ignored; boundary at 100 clk
    send(-16'sd3000, 16'sd0, 16'sd0, 1'b1);
    send(-16'sd200, 16'sd0, 16'sd0, 1'b1);
    exp_cnt++;
    chk("cd_hit_count", int'(hit_count), int'(exp_cnt));
    tick(48);
    send(-16'sd3000, 16'sd0, 16'sd0, 1'b1);
    chk("cd_ignore_state", int'(state_dbg), 2);
    send(-16'sd200, 16'sd0, 16'sd0, 1'b1);
    chk("cd_ignore_pulse", int'(hit_pulse), 0);
    chk("cd_ignore_count", int'(hit_count), int'(exp_cnt));
    tick(47);
    chk("cd_last_cycle", int'(state_dbg), 2);
    tick(1);
    chk("cd_expired", int'(state_dbg), 0);
    send(-16'sd3000, 16'sd0, 16'sd0, 1'b1);
    send(-16'sd200, 16'sd0, 16'sd0, 1'b1);
    exp_cnt++;
    chk("cd_second_pulse", int'(hit_pulse), 1);
    chk("cd_second_count", int'(hit_count), int'(exp_cnt));
    tick(100);

    // Abort on error, then on initialized low
    send(-16'sd3000, 16'sd0, 16'sd0, 1'b1);
    chk("abort_err_armed", int'(state_dbg), 1);
    error = 1'b1;
    tick(1);
    error = 1'b0;
    chk("abort_err_state", int'(state_dbg), 0);
    chk("abort_err_pulse", int'(hit_pulse), 0);
    send(-16'sd200, 16'sd0, 16'sd0, 1'b1);
    chk("abort_err_nohit", int'(hit_pulse), 0);
    chk("abort_err_count", int'(hit_count), int'(exp_cnt));
    send(-16'sd3000, 16'sd0, 16'sd0, 1'b1);
    chk("abort_init_armed", int'(state_dbg), 1);
    initialized = 1'b0;
    tick(1);
    initialized = 1'b1;
    chk("abort_init_state", int'(state_dbg), 0);
    send(-16'sd200, 16'sd0, 16'sd0, 1'b1);
    chk("abort_init_nohit", int'(hit_pulse), 0);
    chk("abort_init_count", int'(hit_count), int'(exp_cnt));

    // Asynchronous reset mid-STRIKE
    send(-16'sd3000, 16'sd0, 16'sd0, 1'b1);
    send(-16'sd6000, 16'sd0, 16'sd0, 1'b1);
    chk("rst_strike_armed", int'(state_dbg), 1);
    rst_n = 1'b0;
    #2;
    chk_zero_outputs("rst_strike");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_strike_release", int'(state_dbg), 0);
    send(-16'sd200, 16'sd0, 16'sd0, 1'b1);
    chk("rst_strike_nohit", int'(hit_pulse), 0);
    chk("rst_strike_count", int'(hit_count), 0);

    // Asynchronous reset mid-COOLDOWN
    send(-16'sd3000, 16'sd0, 16'sd0, 1'b1);
    send(-16'sd200, 16'sd0, 16'sd0, 1'b1);
    chk("rst_cd_hit", int'(hit_count), 1);
    tick(10);
    rst_n = 1'b0;
    #2;
    chk_zero_outputs("rst_cd");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    chk("rst_cd_idle", int'(state_dbg), 0);
    chk("rst_cd_nopulse", int'(hit_pulse), 0);
    send(-16'sd3000, 16'sd0, 16'sd0, 1'b1);
    chk("rst_cd_rearm", int'(state_dbg), 1);
    send(-16'sd200, 16'sd0, 16'sd0, 1'b1);
    chk("rst_cd_rehit", int'(hit_count), 1);
    tick(100);

    // Reset then 256 hits: the counter wraps back to 0
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    for (int n = 0; n < 256; n++) begin
      send(-16'sd3000, 16'sd0, 16'sd0, 1'b1);
      send(-16'sd200, 16'sd0, 16'sd0, 1'b1);
      exp_cnt++;
      chk($sformatf("wrap_count_%0d", n), int'(hit_count), int'(exp_cnt));
      tick(100);
    end
    chk("wrap_final", int'(hit_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
